message_loc_reader: RTL and testbench

MESSAGE_LOC_READER -- requirements
Module: message_loc_reader

---
 rtl/fix_msg_pkg.sv | 17 +
 rtl/msg_skid_buf.sv | 58 +++++
 rtl/message_loc_reader.sv | 143 ++++++++++++++
 tb/tb_message_loc_reader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fix_msg_pkg.sv
// Shared definitions for the message location reader: FSM state encoding
// and the default widths used by the reader and its bench.
package fix_msg_pkg;

    localparam int NUM_MESSAGE_DEF = 5;
    localparam int DATA_WIDTH_DEF  = 5;
    localparam int BYTE_WIDTH_DEF  = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOC_REQ  = 3'd1,
        ST_LOC_WAIT = 3'd2,
        ST_STREAM   = 3'd3,
        ST_DRAIN    = 3'd4
    } state_e;

endpackage

// File: rtl/msg_skid_buf.sv
// Two-entry output buffer holding a byte plus its sop/eop tags; presents the
// head entry on a registered valid/ready port.
module msg_skid_buf #(
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [BYTE_WIDTH-1:0] push_data_i,
    input  logic                  push_sop_i,
    input  logic                  push_eop_i,
    input  logic                  out_ready_i,
    output logic                  out_valid_o,
    output logic [BYTE_WIDTH-1:0] out_data_o,
    output logic                  out_sop_o,
    output logic                  out_eop_o,
    output logic [1:0]            count_o
);

    localparam int W = BYTE_WIDTH + 2;

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic         pop;
    logic [W-1:0] head;

    // Handshake: a byte transfers on a rising edge where out_valid_o and
    // out_ready_i are both high; valid never looks at ready.
    assign pop         = out_valid_o & out_ready_i;
    assign head        = mem_q[rd_ptr_q];
    assign out_valid_o = (count_q != 2'd0);
    assign out_sop_o   = head[W-1];
    assign out_eop_o   = head[W-2];
    assign out_data_o  = head[BYTE_WIDTH-1:0];
    assign count_o     = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= {push_sop_i, push_eop_i, push_data_i};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push_i) - 2'(pop);
        end
    end

endmodule

// File: rtl/message_loc_reader.sv
// Reads message boundaries from a location table, then streams the message
// bytes out of a circular buffer through a two-entry skid buffer.
module message_loc_reader
    import fix_msg_pkg::*;
#(
    parameter int NUM_MESSAGE = NUM_MESSAGE_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int BYTE_WIDTH  = BYTE_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MESSAGE-1:0] wr_count_i,
    output logic [NUM_MESSAGE-1:0] rd_count_o,
    output logic                   loc_rd_o,
    output logic [NUM_MESSAGE-1:0] loc_addr_o,
    input  logic [DATA_WIDTH-1:0]  loc_start_i,
    input  logic [DATA_WIDTH-1:0]  loc_end_i,
    output logic                   buf_rd_o,
    output logic [DATA_WIDTH-1:0]  buf_addr_o,
    input  logic [BYTE_WIDTH-1:0]  buf_data_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [BYTE_WIDTH-1:0]  out_data_o,
    output logic                   out_sop_o,
    output logic                   out_eop_o,
    output logic                   msg_done_o,
    output logic                   busy_o,
    output state_e                 state_o
);

    state_e                 state_q;
    logic [NUM_MESSAGE-1:0] rd_count_q;
    logic [NUM_MESSAGE-1:0] rd_count_d;
    logic [NUM_MESSAGE-1:0] loc_addr_q;
    logic                   loc_rd_q;
    logic [DATA_WIDTH-1:0]  ptr_q;
    logic [DATA_WIDTH-1:0]  ptr_d;
    logic [DATA_WIDTH-1:0]  end_q;
    logic                   first_q;
    logic                   infl_q;
    logic                   infl_sop_q;
    logic                   infl_eop_q;
    logic                   done_q;
    logic [1:0]             skid_count;
    logic [2:0]             occ_after;
    logic                   pop;
    logic                   room;
    logic                   at_end;

    assign pop        = out_valid_o & out_ready_i;
    assign rd_count_d = rd_count_q + NUM_MESSAGE'(1);
    assign ptr_d      = ptr_q + DATA_WIDTH'(1);
    assign at_end     = (ptr_q == end_q);

    // A read may issue only if the byte it returns next cycle is sure of a
    // slot: buffered bytes plus the in-flight byte, less this cycle's pop.
    assign occ_after = 3'(skid_count) + 3'(infl_q) - 3'(pop);
    assign room      = (occ_after <= 3'd1);
    assign buf_rd_o  = (state_q == ST_STREAM) && room;

    assign buf_addr_o = ptr_q;
    assign loc_rd_o   = loc_rd_q;
    assign loc_addr_o = loc_addr_q;
    assign rd_count_o = rd_count_q;
    assign msg_done_o = done_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign state_o    = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            rd_count_q <= '0;
            loc_addr_q <= '0;
            loc_rd_q   <= 1'b0;
            ptr_q      <= '0;
            end_q      <= '0;
            first_q    <= 1'b0;
            infl_q     <= 1'b0;
            infl_sop_q <= 1'b0;
            infl_eop_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            loc_rd_q   <= 1'b0;
            done_q     <= 1'b0;
            infl_q     <= buf_rd_o;
            infl_sop_q <= buf_rd_o & first_q;
            infl_eop_q <= buf_rd_o & at_end;
            case (state_q)
                ST_IDLE: begin
                    if (rd_count_q != wr_count_i) begin
                        state_q    <= ST_LOC_REQ;
                        loc_rd_q   <= 1'b1;
                        loc_addr_q <= rd_count_q;
                    end
                end
                ST_LOC_REQ: begin
                    state_q <= ST_LOC_WAIT;
                end
                ST_LOC_WAIT: begin
                    ptr_q   <= loc_start_i;
                    end_q   <= loc_end_i;
                    first_q <= 1'b1;
                    state_q <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (buf_rd_o) begin
                        ptr_q   <= ptr_d;
                        first_q <= 1'b0;
                        if (at_end) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && out_eop_o) begin
                        done_q     <= 1'b1;
                        rd_count_q <= rd_count_d;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    msg_skid_buf #(
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .push_i      (infl_q),
        .push_data_i (buf_data_i),
        .push_sop_i  (infl_sop_q),
        .push_eop_i  (infl_eop_q),
        .out_ready_i (out_ready_i),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_sop_o   (out_sop_o),
        .out_eop_o   (out_eop_o),
        .count_o     (skid_count)
    );

endmodule

// File: tb/tb_message_loc_reader.sv
// Randomized bench for message_loc_reader: table/buffer responders, a
// message-level reference model feeding an expected-byte queue, and checks.
module tb_message_loc_reader;
    import fix_msg_pkg::*;

    localparam int NM = 5;
    localparam int DW = 5;
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NM-1:0] wr_count_i = '0;
    logic [NM-1:0] rd_count_o;
    logic          loc_rd_o;
    logic [NM-1:0] loc_addr_o;
    logic [DW-1:0] loc_start_i = '0;
    logic [DW-1:0] loc_end_i = '0;
    logic          buf_rd_o;
    logic [DW-1:0] buf_addr_o;
    logic [BW-1:0] buf_data_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b1;
    logic [BW-1:0] out_data_o;
    logic          out_sop_o;
    logic          out_eop_o;
    logic          msg_done_o;
    logic          busy_o;
    state_e        state_o;

    always #5 clk = ~clk;

    message_loc_reader #(
        .NUM_MESSAGE (NM),
        .DATA_WIDTH  (DW),
        .BYTE_WIDTH  (BW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_count_i  (wr_count_i),
        .rd_count_o  (rd_count_o),
        .loc_rd_o    (loc_rd_o),
        .loc_addr_o  (loc_addr_o),
        .loc_start_i (loc_start_i),
        .loc_end_i   (loc_end_i),
        .buf_rd_o    (buf_rd_o),
        .buf_addr_o  (buf_addr_o),
        .buf_data_i  (buf_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_sop_o   (out_sop_o),
        .out_eop_o   (out_eop_o),
        .msg_done_o  (msg_done_o),
        .busy_o      (busy_o),
        .state_o     (state_o)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [BW+1:0] exp_q[$];
    logic [BW-1:0] mem [32];
    logic [DW-1:0] tbl_s [32];
    logic [DW-1:0] tbl_e [32];
    logic [NM-1:0] rd_model = '0;
    logic [NM-1:0] loc_idx_model = '0;
    int            msgs_done = 0;
    int            msgs_target = 0;
    int            hs_cnt = 0;
    int            cyc = 0;
    int            hs_cyc[$];
    bit            done_due = 1'b0;
    bit            prev_stall = 1'b0;
    logic [BW+1:0] prev_word = '0;
    int            rdy_mode = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Table and buffer responders: data valid one cycle after the strobe.
    always @(posedge clk) begin
        if (loc_rd_o) begin
            loc_start_i <= tbl_s[loc_addr_o];
            loc_end_i   <= tbl_e[loc_addr_o];
        end
        if (buf_rd_o) begin
            buf_data_i <= mem[buf_addr_o];
        end
    end

    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       out_ready_i = 1'b1;
            1:       out_ready_i = ~out_ready_i;
            default: out_ready_i = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: values seen at the falling edge are what the next rising edge uses.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            if (prev_stall) begin
                chk("hold", 32'({out_valid_o, out_sop_o, out_eop_o, out_data_o}),
                    32'({1'b1, prev_word}));
            end
            if (msg_done_o || done_due) begin
                chk("msg_done", 32'(msg_done_o), 32'(done_due));
            end
            if (msg_done_o) begin
                rd_model++;
                msgs_done++;
                chk("rd_count", 32'(rd_count_o), 32'(rd_model));
            end
            done_due = 1'b0;
            if (loc_rd_o) begin
                chk("loc_addr", 32'(loc_addr_o), 32'(loc_idx_model));
                loc_idx_model++;
            end
            prev_stall = out_valid_o && !out_ready_i;
            prev_word  = {out_sop_o, out_eop_o, out_data_o};
            if (out_valid_o && out_ready_i) begin
                hs_cnt++;
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("extra_byte", 32'(1), 32'(0));
                end else begin
                    chk("byte", 32'({out_sop_o, out_eop_o, out_data_o}), 32'(exp_q.pop_front()));
                end
                if (out_eop_o) done_due = 1'b1;
            end
        end
    end

    // Reference model: a message is the bytes from start up to end, walking
    // the circular buffer; wr_count_i then advances by one.
    task automatic issue(input int n);
        logic [NM-1:0] idx;
        logic [DW-1:0] a;
        int            len;
        for (int k = 0; k < n; k++) begin
            idx = wr_count_i;
            len = int'(DW'(tbl_e[idx] - tbl_s[idx])) + 1;
            for (int i = 0; i < len; i++) begin
                a = tbl_s[idx] + DW'(i);
                exp_q.push_back({(i == 0), (i == len - 1), mem[a]});
            end
            wr_count_i = wr_count_i + 1'b1;
            msgs_target++;
        end
    endtask

    task automatic wait_msgs();
        int t = 0;
        while (msgs_done < msgs_target && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("msgs_done", 32'(msgs_done), 32'(msgs_target));
    endtask

    task automatic fill_mem();
        int base = int'($urandom_range(0, 255));
        for (int a = 0; a < 32; a++) mem[a] = 8'(a * 37 + base);
    endtask

    initial begin
        int lat;
        int start_cnt;
        int t;
        fill_mem();
        for (int i = 0; i < 32; i++) begin
            tbl_s[i] = DW'($urandom_range(0, 31));
            tbl_e[i] = tbl_s[i] + DW'($urandom_range(0, 7));
        end
        repeat (3) @(negedge clk);
        chk("rst_ctl", 32'({loc_rd_o, buf_rd_o, out_valid_o, out_sop_o, out_eop_o, msg_done_o, busy_o}), 32'(0));
        chk("rst_cnt", 32'({rd_count_o, loc_addr_o, buf_addr_o}), 32'(0));
        chk("rst_data", 32'(out_data_o), 32'(0));
        rst = 1'b1;
        @(negedge clk);

        // Contiguous message with first-byte latency and full-rate streaming
        tbl_s[0] = 5'd3; tbl_e[0] = 5'd6;
        hs_cyc.delete();
        issue(1);
        @(posedge clk);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid_o) break;
        end
        chk("latency", 32'(lat), 32'(4));
        wait_msgs();
        chk("s1_len", 32'(hs_cyc.size()), 32'(4));
        if (hs_cyc.size() == 4) chk("s1_rate", 32'(hs_cyc[3] - hs_cyc[0]), 32'(3));
        @(negedge clk);
        chk("s1_idle", 32'({busy_o, rd_count_o}), 32'({1'b0, 5'd1}));

        // Wrapping message, then a single-byte message
        tbl_s[1] = 5'd30; tbl_e[1] = 5'd1;
        hs_cyc.delete();
        issue(1);
        wait_msgs();
        chk("s2_len", 32'(hs_cyc.size()), 32'(4));
        tbl_s[2] = 5'd9; tbl_e[2] = 5'd9;
        issue(1);
        wait_msgs();

        // Eight bytes under an alternating ready pattern
        tbl_s[3] = 5'd12; tbl_e[3] = 5'd19;
        rdy_mode = 1;
        issue(1);
        wait_msgs();

        // Randomized messages and backpressure, including writes while busy
        rdy_mode = 2;
        for (int r = 0; r < 8; r++) begin
            fill_mem();
            issue(int'($urandom_range(1, 3)));
            repeat (int'($urandom_range(0, 6))) @(negedge clk);
            wait_msgs();
        end

        // Walk the read count up to 31, then read index 31 and wrap to 0
        rdy_mode = 0;
        issue(31 - int'(wr_count_i));
        wait_msgs();
        chk("s5_rd31", 32'(rd_count_o), 32'(31));
        issue(1);
        wait_msgs();
        chk("s5_wrap", 32'(rd_count_o), 32'(0));

        // Reset during the third byte, then replay index 0 from the start
        tbl_s[0] = 5'd10; tbl_e[0] = 5'd20;
        start_cnt = hs_cnt;
        issue(1);
        t = 0;
        while (hs_cnt < start_cnt + 2 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("s6_reach", 32'(hs_cnt - start_cnt), 32'(2));
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("s6_rst_ctl", 32'({loc_rd_o, buf_rd_o, out_valid_o, out_sop_o, out_eop_o, msg_done_o, busy_o}), 32'(0));
        chk("s6_rst_cnt", 32'({rd_count_o, loc_addr_o, buf_addr_o}), 32'(0));
        chk("s6_rst_data", 32'(out_data_o), 32'(0));
        exp_q.delete();
        done_due = 1'b0;
        prev_stall = 1'b0;
        rd_model = '0;
        loc_idx_model = '0;
        msgs_target = msgs_done;
        repeat (2) @(negedge clk);
        wr_count_i = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        issue(1);
        wait_msgs();
        chk("s6_rd_count", 32'(rd_count_o), 32'(1));
        chk("s6_leftover", 32'(exp_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
